// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - shared types and constants for the I2C register sequencer
//
// Purpose: state and response-status encodings plus the drain-idle length
//          used by i2c_reg_sequencer.
// Ports:   none (package).
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RSTART,
    LAST,
    DRAIN,
    RESP
  } seq_state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_NACK    = 2'b01,
    ST_TIMEOUT = 2'b10
  } rsp_status_t;

  // Cycles busy_s must stay low after the last byte before the master is
  // considered back in READY (STOP finished).
  localparam int DRAIN_IDLE_CYCLES = 2;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - multi-flop synchroniser with rise/fall pulse outputs
//
// Purpose: brings an asynchronous level into the clk domain and produces
//          single-cycle pulses on each edge of the synchronised copy.
// Ports:
//   clk       in  system clock
//   rst_n     in  synchronous active-low reset (all flops to 0)
//   async_in  in  asynchronous level
//   sync_out  out synchronised level (SYNC_STAGES flops deep)
//   rise      out one-cycle pulse when sync_out goes 0->1
//   fall      out one-cycle pulse when sync_out goes 1->0
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - turns one host register request into an i2c_master byte sequence
//
// Purpose: accepts a (dev, reg) write of one byte or a (dev, reg) repeated-start
//          read of one byte, drives the byte-level master, and returns one
//          response (data + status) per request.
// Optional: `define I2C_REG_SEQUENCER_TIMEOUT_EN adds a watchdog that aborts a
//          transaction when no busy edge is seen for TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst_n                          system clock, synchronous active-low reset
//   req_valid/req_ready                 request handshake (ready only in IDLE)
//   req_dev, req_reg, req_wr, req_wdata request fields, registered on accept
//   rsp_valid, rsp_rdata, rsp_status    one-cycle response strobe and payload
//   m_enable, m_slv_addr, m_rnw, m_data_wr  command to the i2c_master
//   m_busy, m_rd_data, m_nack           status from the i2c_master (SCL domain)
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic       req_wr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic       m_enable,
  output logic [6:0] m_slv_addr,
  output logic       m_rnw,
  output logic [7:0] m_data_wr,
  input  logic       m_busy,
  input  logic [7:0] m_rd_data,
  input  logic       m_nack
);

  localparam int DRAIN_W = $clog2(DRAIN_IDLE_CYCLES + 1);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("i2c_reg_sequencer: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  seq_state_t state_q, state_d;

  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic       wr_q;

  logic busy_s, busy_rise, busy_fall;
  logic nack_s, nack_rise_unused, nack_fall_unused;

  logic               accept;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic               drain_done;
  logic               timeout_hit;
  logic               timed_out;
  rsp_status_t        status_sel;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_busy_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (m_busy),
    .sync_out (busy_s),
    .rise     (busy_rise),
    .fall     (busy_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nack_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (m_nack),
    .sync_out (nack_s),
    .rise     (nack_rise_unused),
    .fall     (nack_fall_unused)
  );

  assign accept = req_valid && (state_q == IDLE);

  // Request fields are captured once so the host is free to change them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      dev_q   <= req_dev;
      reg_q   <= req_reg;
      wdata_q <= req_wdata;
      wr_q    <= req_wr;
    end
  end

  // Counts consecutive busy_s=0 cycles while in DRAIN.
  assign drain_done = (state_q == DRAIN) && !busy_s &&
                      (drain_cnt_q == DRAIN_W'(DRAIN_IDLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_cnt_q <= '0;
    end else if (state_q != DRAIN || busy_s) begin
      drain_cnt_q <= '0;
    end else if (!drain_done) begin
      drain_cnt_q <= drain_cnt_q + 1'b1;
    end
  end

`ifdef I2C_REG_SEQUENCER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timed_out_q;
  logic            to_active;

  assign to_active = (state_q == ADDR) || (state_q == DATA) || (state_q == RSTART) ||
                     (state_q == LAST) || (state_q == DRAIN);

  // A busy edge in the same cycle restarts the window instead of aborting.
  assign timeout_hit = to_active && !busy_rise && !busy_fall &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
    end else if (accept) begin
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if (busy_rise || busy_fall) begin
        to_cnt_q <= '0;
      end else if (to_active && !timeout_hit) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        timed_out_q <= 1'b1;
      end
    end
  end

  assign timed_out = timed_out_q;
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (accept)     state_d = ADDR;
      // First busy_rise: master has latched address + register byte.
      ADDR:         if (busy_rise)  state_d = wr_q ? DATA : RSTART;
      // Second busy_rise: master has latched the final byte command.
      DATA, RSTART: if (busy_rise)  state_d = LAST;
      LAST:         if (busy_fall)  state_d = DRAIN;
      DRAIN:        if (drain_done) state_d = RESP;
      RESP:                         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
    if (timeout_hit) begin
      state_d = RESP;
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    m_enable   = 1'b0;
    m_slv_addr = '0;
    m_rnw      = 1'b0;
    m_data_wr  = '0;
    rsp_valid  = 1'b0;
    rsp_rdata  = '0;
    status_sel = ST_OK;

    if (state_q != IDLE) begin
      m_slv_addr = dev_q;
    end

    case (state_q)
      IDLE: req_ready = 1'b1;
      ADDR: begin
        m_enable  = 1'b1;
        m_data_wr = reg_q;
      end
      DATA: begin
        m_enable  = 1'b1;
        m_data_wr = wdata_q;
      end
      // Same address with RnW=1 makes the master issue a repeated start.
      RSTART: begin
        m_enable  = 1'b1;
        m_rnw     = 1'b1;
        m_data_wr = reg_q;
      end
      // Hold the last command stable while the master finishes and STOPs.
      LAST, DRAIN: begin
        m_rnw     = !wr_q;
        m_data_wr = wr_q ? wdata_q : reg_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (timed_out) begin
          status_sel = ST_TIMEOUT;
        end else begin
          status_sel = nack_s ? ST_NACK : ST_OK;
          rsp_rdata  = wr_q ? 8'h00 : m_rd_data;
        end
      end
      default: ;
    endcase

    rsp_status = status_sel;
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb/tb_i2c_reg_sequencer.sv - self-checking bench for i2c_reg_sequencer with a behavioural master/slave
module tb_i2c_reg_sequencer;

  localparam int         RS_MARK   = 256;
  localparam logic [6:0] SLAVE_DEV = 7'h50;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic       req_wr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic       m_enable;
  logic [6:0] m_slv_addr;
  logic       m_rnw;
  logic [7:0] m_data_wr;
  logic       m_busy;
  logic [7:0] m_rd_data;
  logic       m_nack;

  i2c_reg_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(1000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dev    (req_dev),
    .req_reg    (req_reg),
    .req_wr     (req_wr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_status (rsp_status),
    .m_enable   (m_enable),
    .m_slv_addr (m_slv_addr),
    .m_rnw      (m_rnw),
    .m_data_wr  (m_data_wr),
    .m_busy     (m_busy),
    .m_rd_data  (m_rd_data),
    .m_nack     (m_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] d;
    logic [1:0] s;
    logic       en;
  } rsp_t;

  rsp_t rsp_q[$];
  int   bus_q[$];
  int   exp_q[$];

  logic [7:0] slave_mem [256];
  logic [7:0] ref_mem   [256];
  logic       mst_on;
  logic       mst_idle;

  always @(negedge clk) begin
    if (rsp_valid) rsp_q.push_back('{c: cyc, d: rsp_rdata, s: rsp_status, en: m_enable});
  end

  // Byte-level master plus one slave at SLAVE_DEV with a register pointer.
  // Each busy high period is one latched command; busy falls at byte end and
  // the master continues only if enable is still high, otherwise it STOPs.
  initial begin : master_model
    logic [6:0] a;
    logic       r;
    logic [7:0] d;
    logic [7:0] prev_ar;
    logic [7:0] ptr;
    bit         first, more, have_ptr, ack;
    m_busy    = 1'b0;
    m_nack    = 1'b0;
    m_rd_data = 8'h00;
    mst_idle  = 1'b1;
    ptr       = 8'h00;
    prev_ar   = 8'h00;
    ack       = 1'b0;
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'(i * 37 + 11);
    slave_mem[8'h22] = 8'h3C;
    forever begin
      @(negedge clk);
      if (mst_on && m_enable) begin
        mst_idle = 1'b0;
        m_nack   = 1'b0;
        first    = 1'b1;
        have_ptr = 1'b0;
        do begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          a = m_slv_addr;
          r = m_rnw;
          d = m_data_wr;
          if (first || {a, r} != prev_ar) begin
            if (!first) bus_q.push_back(RS_MARK);
            bus_q.push_back(int'({a, r}));
            ack = (a == SLAVE_DEV);
            if (!ack) m_nack = 1'b1;
          end
          prev_ar = {a, r};
          first   = 1'b0;
          m_busy  = 1'b1;
          repeat ($urandom_range(6, 12)) @(negedge clk);
          if (r) begin
            m_rd_data = ack ? slave_mem[ptr] : 8'hFF;
            bus_q.push_back(int'(m_rd_data));
          end else begin
            bus_q.push_back(int'(d));
            if (ack) begin
              if (!have_ptr) begin
                ptr      = d;
                have_ptr = 1'b1;
              end else begin
                slave_mem[ptr] = d;
                ptr            = ptr + 8'd1;
              end
            end
          end
          m_busy = 1'b0;
          more   = m_enable;
        end while (more);
        repeat ($urandom_range(2, 5)) @(negedge clk);
        mst_idle = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: what a one-byte register write / repeated-start read must look like on the bus.
  task automatic expect_txn(input logic [6:0] dev, input logic [7:0] rg, input logic wr,
                            input logic [7:0] wd, output logic [7:0] e_rd, output logic [1:0] e_st);
    bit present;
    present = (dev == SLAVE_DEV);
    exp_q.delete();
    exp_q.push_back(int'({dev, 1'b0}));
    exp_q.push_back(int'(rg));
    if (wr) begin
      exp_q.push_back(int'(wd));
      e_rd = 8'h00;
      if (present) ref_mem[rg] = wd;
    end else begin
      e_rd = present ? ref_mem[rg] : 8'hFF;
      exp_q.push_back(RS_MARK);
      exp_q.push_back(int'({dev, 1'b1}));
      exp_q.push_back(int'(e_rd));
    end
    e_st = present ? 2'b00 : 2'b01;
  endtask

  task automatic wait_master_idle();
    int n = 0;
    while (!mst_idle && n < 2000) begin @(negedge clk); n++; end
    check("master_idle_in_budget", n < 2000, 1);
  endtask

  task automatic send_req(input logic [6:0] dev, input logic [7:0] rg, input logic wr,
                          input logic [7:0] wd, output int acc_c);
    int n = 0;
    @(negedge clk);
    req_dev = dev; req_reg = rg; req_wr = wr; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && n < 20000) begin @(negedge clk); n++; end
    check("accept_in_budget", n < 20000, 1);
    acc_c = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_dev   = 7'($urandom);
    req_reg   = 8'($urandom);
    req_wr    = 1'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic wait_rsp(input int target, input int limit);
    int n = 0;
    while (rsp_q.size() < target && n < limit) begin @(negedge clk); n++; end
    check("rsp_in_budget", rsp_q.size() >= target, 1);
  endtask

  task automatic run_txn(input string tag, input logic [6:0] dev, input logic [7:0] rg,
                         input logic wr, input logic [7:0] wd);
    logic [7:0] e_rd;
    logic [1:0] e_st;
    int         base, acc_c, bad;
    wait_master_idle();
    bus_q.delete();
    base = rsp_q.size();
    expect_txn(dev, rg, wr, wd, e_rd, e_st);
    send_req(dev, rg, wr, wd, acc_c);
    wait_rsp(base + 1, 5000);
    if (rsp_q.size() > base) begin
      check({tag, "_rdata"}, rsp_q[base].d, e_rd);
      check({tag, "_status"}, rsp_q[base].s, e_st);
      check({tag, "_enable_low_at_rsp"}, rsp_q[base].en, 0);
    end
    @(negedge clk);
    check({tag, "_ready_back"}, req_ready, 1);
    repeat (20) @(negedge clk);
    check({tag, "_one_rsp"}, rsp_q.size(), base + 1);
    wait_master_idle();
    bad = (bus_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < bus_q.size() && i < exp_q.size(); i++) if (bus_q[i] != exp_q[i]) bad++;
    check({tag, "_bus_bytes"}, bad, 0);
  endtask

  initial begin : main
    logic [7:0] e_rd_a, e_rd_b;
    logic [1:0] e_st_a, e_st_b;
    int         base, acc_c, n;
    logic [6:0] rdev;

    mst_on    = 1'b1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_dev   = '0;
    req_reg   = '0;
    req_wr    = 1'b0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    ref_mem[8'h22] = 8'h3C;

    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_status", rsp_status, 0);
    check("reset_m_enable", m_enable, 0);
    check("reset_m_slv_addr", m_slv_addr, 0);
    check("reset_m_rnw", m_rnw, 0);
    check("reset_m_data_wr", m_data_wr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn("wr_50_10", 7'h50, 8'h10, 1'b1, 8'hA5);
    run_txn("rd_50_22", 7'h50, 8'h22, 1'b0, 8'h00);
    run_txn("wr_absent", 7'h12, 8'h10, 1'b1, 8'h77);
    run_txn("rd_absent", 7'h12, 8'h22, 1'b0, 8'h00);

    // Second request held valid during the first: accepted only after first response.
    wait_master_idle();
    base = rsp_q.size();
    expect_txn(7'h50, 8'h22, 1'b0, 8'h00, e_rd_a, e_st_a);
    expect_txn(7'h50, 8'h05, 1'b1, 8'hC3, e_rd_b, e_st_b);
    @(negedge clk);
    req_dev = 7'h50; req_reg = 8'h22; req_wr = 1'b0; req_wdata = 8'h00; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    req_reg = 8'h05; req_wr = 1'b1; req_wdata = 8'hC3;
    n = 0;
    while (!req_ready && n < 20000) begin @(negedge clk); n++; end
    check("b2b_second_accepted", n < 20000, 1);
    acc_c = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(base + 2, 5000);
    repeat (20) @(negedge clk);
    check("b2b_two_rsps", rsp_q.size(), base + 2);
    if (rsp_q.size() >= base + 2) begin
      check("b2b_accept_after_rsp1", acc_c > rsp_q[base].c, 1);
      check("b2b_rsp1_rdata", rsp_q[base].d, e_rd_a);
      check("b2b_rsp1_status", rsp_q[base].s, e_st_a);
      check("b2b_rsp2_rdata", rsp_q[base + 1].d, e_rd_b);
      check("b2b_rsp2_status", rsp_q[base + 1].s, e_st_b);
    end

    // Reset pulse while the write data byte is being offered to the master.
    wait_master_idle();
    base = rsp_q.size();
    send_req(7'h50, 8'h33, 1'b1, 8'h5A, acc_c);
    n = 0;
    while (!(m_enable && !m_rnw && m_data_wr == 8'h5A) && n < 2000) begin @(negedge clk); n++; end
    check("abort_reached_data", n < 2000, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_enable_low", m_enable, 0);
    check("abort_idle_ready", req_ready, 1);
    check("abort_no_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    wait_master_idle();
    repeat (100) @(negedge clk);
    check("abort_no_response", rsp_q.size(), base);

    // Randomized traffic against the register-file reference.
    for (int k = 0; k < 20; k++) begin
      rdev = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_DEV;
      if (rdev == SLAVE_DEV && $urandom_range(0, 4) == 0) rdev = 7'h51;
      run_txn($sformatf("rand%0d", k), rdev, 8'($urandom_range(0, 7)),
              1'($urandom), 8'($urandom));
    end

    // Master that never raises busy.
    wait_master_idle();
    mst_on = 1'b0;
    base   = rsp_q.size();
    send_req(7'h50, 8'h01, 1'b1, 8'h99, acc_c);
`ifdef I2C_REG_SEQUENCER_TIMEOUT_EN
    wait_rsp(base + 1, 2000);
    if (rsp_q.size() > base) begin
      check("timeout_status", rsp_q[base].s, 2'b10);
      check("timeout_rdata", rsp_q[base].d, 0);
      check("timeout_enable_low", rsp_q[base].en, 0);
      check("timeout_latency", (rsp_q[base].c - acc_c >= 995) && (rsp_q[base].c - acc_c <= 1010), 1);
    end
`else
    repeat (5000) @(negedge clk);
    check("stall_no_response", rsp_q.size(), base);
    check("stall_still_busy", req_ready, 0);
    check("stall_enable_held", m_enable, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("stall_reset_recovers", req_ready, 1);
`endif
    mst_on = 1'b1;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
